// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10GBASE-R PHY blocks: TX gearbox, RX frame aligner and PCS.
// Contents:
//   DATA_WIDTH / HDR_WIDTH / FRAME_WIDTH  payload, sync-header and 66b block widths
//   SEQ_LEN                               gearbox sequence length (32 blocks -> 33 words)
//   SYNC_DATA / SYNC_CTRL                 legal sync-header values
//   gb_phase_t                            gearbox cycle type (accept a block or drain)
//   sync_hdr_invalid()                    flags the two illegal header codes
package eth_phy_10g_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int HDR_WIDTH   = 2;
    localparam int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH;
    localparam int SEQ_LEN     = 33;

    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

    typedef enum logic {
        GB_ACCEPT = 1'b0,
        GB_PAUSE  = 1'b1
    } gb_phase_t;

    // 2'b00 and 2'b11 carry no transition and are not valid sync headers.
    function automatic logic sync_hdr_invalid(input logic [HDR_WIDTH-1:0] hdr);
        return hdr[0] ~^ hdr[1];
    endfunction

endpackage

// File: rtl/eth_phy_10g_tx_gearbox_if.sv
// Bundle between the TX PCS encoder/scrambler, the 66b->64b gearbox and the SerDes.
// Signals:
//   i_tx_data, i_tx_hdr   66b block from the encoder (payload + sync header)
//   o_tx_ready            block consumed this cycle when 1
//   o_serdes_tx_data      64b SerDes word, bit 0 transmitted first
//   o_serdes_tx_valid     SerDes word holds gearbox output
//   o_tx_hdr_err          one-cycle pulse for an illegal consumed header
// Modports: master = block source / SerDes sink side, slave = gearbox.
interface eth_phy_10g_tx_gearbox_if;
    import eth_phy_10g_pkg::*;

    logic [DATA_WIDTH-1:0] i_tx_data;
    logic [HDR_WIDTH-1:0]  i_tx_hdr;
    logic                  o_tx_ready;
    logic [DATA_WIDTH-1:0] o_serdes_tx_data;
    logic                  o_serdes_tx_valid;
    logic                  o_tx_hdr_err;

    modport master (
        output i_tx_data,
        output i_tx_hdr,
        input  o_tx_ready,
        input  o_serdes_tx_data,
        input  o_serdes_tx_valid,
        input  o_tx_hdr_err
    );

    modport slave (
        input  i_tx_data,
        input  i_tx_hdr,
        output o_tx_ready,
        output o_serdes_tx_data,
        output o_serdes_tx_valid,
        output o_tx_hdr_err
    );

endinterface

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 10GBASE-R transmit gearbox: packs one 66b block per cycle (header first, LSB first)
// into a continuous stream of 64b SerDes words. Every 33rd cycle the source is held off
// and the 64 bits accumulated over the previous 32 blocks are emitted as a whole word.
// Ports:
//   clk   single rising-edge clock
//   rst   synchronous active-low reset (0 = in reset)
//   bus   eth_phy_10g_tx_gearbox_if.slave (block input, ready, SerDes output, header error)
module eth_phy_10g_tx_gearbox
    import eth_phy_10g_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    eth_phy_10g_tx_gearbox_if.slave      bus
);

    localparam int SEQ_CNT_W = 6;
    localparam int FILL_W    = 7;
    localparam int WIN_WIDTH = DATA_WIDTH + FRAME_WIDTH;
    localparam logic [SEQ_CNT_W-1:0] SEQ_LAST = SEQ_CNT_W'(SEQ_LEN - 1);

    logic [SEQ_CNT_W-1:0]   seq_cnt;
    logic [DATA_WIDTH-1:0]  buffer;
    logic [FILL_W-1:0]      fill;
    logic [FRAME_WIDTH-1:0] frame;
    logic [WIN_WIDTH-1:0]   window;
    gb_phase_t              phase;

    logic [DATA_WIDTH-1:0]  word_p1;
    logic                   vld_p1;
    logic                   hdr_err_p1;

    // Each block adds 66 bits and each word removes 64, so the residue grows by
    // exactly 2 bits per accepted block.
    assign fill  = {seq_cnt, 1'b0};
    assign frame = {bus.i_tx_data, bus.i_tx_hdr};

    // Residue bits above fill are always zero, so a plain OR merges the new block.
    assign window = {{FRAME_WIDTH{1'b0}}, buffer} | (WIN_WIDTH'(frame) << fill);

    // fill never exceeds 62 on an accept, so the top two window bits stay zero.
    logic unused_window_msbs;
    assign unused_window_msbs = ^window[WIN_WIDTH-1:2*DATA_WIDTH];

    always_comb begin
        phase = GB_ACCEPT;
        if (seq_cnt == SEQ_LAST) begin
            phase = GB_PAUSE;
        end
    end

    assign bus.o_tx_ready = rst && (phase == GB_ACCEPT);

    // Stage p1: registered SerDes word, valid and header error
    always_ff @(posedge clk) begin
        if (!rst) begin
            seq_cnt    <= '0;
            buffer     <= '0;
            word_p1    <= '0;
            vld_p1     <= 1'b0;
            hdr_err_p1 <= 1'b0;
        end else if (phase == GB_PAUSE) begin
            word_p1    <= buffer;
            buffer     <= '0;
            seq_cnt    <= '0;
            hdr_err_p1 <= 1'b0;
        end else begin
            word_p1    <= window[DATA_WIDTH-1:0];
            buffer     <= window[2*DATA_WIDTH-1:DATA_WIDTH];
            seq_cnt    <= seq_cnt + 1'b1;
            vld_p1     <= 1'b1;
            hdr_err_p1 <= sync_hdr_invalid(bus.i_tx_hdr);
        end
    end

    assign bus.o_serdes_tx_data  = word_p1;
    assign bus.o_serdes_tx_valid = vld_p1;
    assign bus.o_tx_hdr_err      = hdr_err_p1;

endmodule
